serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//  Upstream stimulus stage for the serial pattern detector.
//  - Loads a WIDTH-bit word and shifts it out MSB-first as a serial bit w_out; each bit is held TICK_DIV clocks.
//  - Emits bit_strobe on the last cycle of each bit period; the detector uses it as its state-advance enable.
//  - Optional repeat mode streams the latched word continuously, so pattern runs can be driven from switches.
// PARAMETERS
//  WIDTH     8           bits per loaded word (>=2)
//  TICK_DIV  25000000    clocks per serial bit (>=1); 0.5 s at 50 MHz
// PORTS
//  clock       in   1      system clock; all state changes on its rising edge
//  reset       in   1      synchronous, active-high; wins over every other input
//  load        in   1      start request; sampled only in IDLE
//  data_in     in   WIDTH  word to send; captured on accepted load
//  repeat_en   in   1      1: reload latched word after last bit and continue
//  abort       in   1      synchronous stop; returns to IDLE, no done pulse
//  w_out       out  1      current serial bit (registered)
//  w_valid     out  1      1 while w_out carries a word bit
//  bit_strobe  out  1      1-cycle pulse on last clock of each bit period
//  busy        out  1      1 in SHIFT state
//  done        out  1      1-cycle pulse after last bit of a non-repeating word
//  bit_idx     out  $clog2(WIDTH)  index of bit on w_out (WIDTH-1 down to 0)
// BEHAVIOUR
//  - Reset: state=IDLE. Outputs w_out=0, w_valid=0, bit_strobe=0, busy=0, done=0, bit_idx=WIDTH-1.
//    Word latch, shift register and divider are cleared.
//  - States: IDLE, SHIFT (2 states).
//  - IDLE, load=1 (edge N): data_in goes to word_q and shreg; div_cnt=0; bit_idx=WIDTH-1; -> SHIFT.
//    From N+1: w_out=data_in[WIDTH-1], w_valid=1, busy=1. Latency from load to first bit is 1 clock.
//  - SHIFT: div_cnt counts 0..TICK_DIV-1 and wraps to 0.
//    bit_strobe=1 while div_cnt==TICK_DIV-1 (combinational from registered count).
//  - At a strobe edge with bit_idx>0: shreg shifts left 1, bit_idx decrements.
//  - At a strobe edge with bit_idx==0:
//    - repeat_en=1: shreg<=word_q, bit_idx<=WIDTH-1, stay in SHIFT. No gap between words.
//    - repeat_en=0: -> IDLE. done=1 for the next cycle; w_valid, busy and w_out return to 0.
//  - repeat_en is sampled only at the bit_idx==0 strobe edge. It may change freely at other times.
//  - load in SHIFT is ignored; word_q is not updated.
//  - abort=1 in SHIFT: -> IDLE at the next edge, done stays 0, div_cnt=0. abort in IDLE: no effect.
//  - Priority on the same edge: reset > abort > strobe/load.
//  - TICK_DIV=1: bit_strobe is constantly 1 in SHIFT, giving one bit per clock.
//  - Each bit is valid for exactly TICK_DIV cycles. One word takes WIDTH*TICK_DIV cycles.
//  - Widths: div_cnt uses $clog2(TICK_DIV) bits, minimum 1. All compares are against TICK_DIV-1 at that width.
// STRUCTURE
//  - Shared package serial_pkg: state localparams (IDLE=1'b0, SHIFT=1'b1) and a CLOG2 helper for counter widths.
//  - One sub-module, rate_divider(clock, reset, clear, enable, tick), parameterised by TICK_DIV.
//    It owns div_cnt and produces bit_strobe. The FSM, shreg, word_q and bit_idx stay in the top.
//  - State transition logic and output logic are written as separate blocks.
// TESTING  (WIDTH=8, TICK_DIV=3)
//  1. Reset asserted mid-word -> next cycle all outputs 0, bit_idx=7. A load afterwards restarts cleanly.
//  2. load, data_in=8'b1011_0001, repeat_en=0 -> w_out sequence 1,0,1,1,0,0,0,1, each held 3 cycles.
//     bit_strobe on cycles 3,6,..,24 after load. done pulses at cycle 25.
//  3. repeat_en=1, data_in=8'hA5 -> back-to-back A5 streams with no idle cycle between words, for 3 words.
//     Then drop repeat_en -> done after the 3rd or current word's last bit.
//  4. load=1 with data_in=8'hFF during SHIFT of 8'h0F -> output stays 0,0,0,0,1,1,1,1. word_q is unchanged.
//  5. abort at bit_idx=4 -> IDLE next cycle, done=0. A subsequent load of 8'h3C shifts from bit 7.
//  6. Instantiate with TICK_DIV=1 and feed the serial pattern detector with bit_strobe as its advance enable.
//     Stream 8'b0111_0110 (pattern 1101 embedded) -> detector output asserts on the expected bit positions.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit feeder: FSM states and a width helper.
package serial_pkg;

    // Feeder FSM: waiting for a word, or shifting one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_bit_feeder_rate_divider.sv
// Bit-period divider: counts clocks while enabled and ticks on the last clock of each period.
module rate_divider #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    import serial_pkg::*;

    localparam int            CW   = clog2_min1(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign tick = enable && (div_cnt_q == LAST);

    // Next count: clear restarts the period, otherwise count up and wrap after LAST.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clear) begin
            div_cnt_d = '0;
        end else if (enable) begin
            if (div_cnt_q == LAST) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + CW'(1);
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/serial_bit_feeder.sv
// Serial bit feeder: shifts a latched word out MSB-first, one bit per TICK_DIV clocks,
// optionally repeating the word back-to-back, with a strobe on the last clock of each bit.
module serial_bit_feeder #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 25000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     repeat_en,
    input  logic                     abort,
    output logic                     w_out,
    output logic                     w_valid,
    output logic                     bit_strobe,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);
    import serial_pkg::*;

    localparam int            IW      = $clog2(WIDTH);
    localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [IW-1:0]    bit_idx_q;
    logic [IW-1:0]    bit_idx_d;
    logic             done_q;
    logic             done_d;
    logic             in_shift;
    logic             last_bit;
    logic             div_clear;

    assign in_shift = (state_q == SHIFT);
    assign last_bit = bit_strobe && (bit_idx_q == '0);

    rate_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_rate_divider (
        .clock (clock),
        .reset (reset),
        .clear (div_clear),
        .enable(in_shift),
        .tick  (bit_strobe)
    );

    // State transitions: abort beats the end-of-word decision; load only counts in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_bit && !repeat_en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture on load, shift on each strobe, reload or finish after the last bit.
    always_comb begin
        word_d    = word_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        div_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    word_d    = data_in;
                    shreg_d   = data_in;
                    bit_idx_d = TOP_IDX;
                    div_clear = 1'b1;
                end
            end
            SHIFT: begin
                if (abort) begin
                    bit_idx_d = TOP_IDX;
                    div_clear = 1'b1;
                end else if (bit_strobe) begin
                    if (bit_idx_q != '0) begin
                        shreg_d   = shreg_q << 1;
                        bit_idx_d = bit_idx_q - IW'(1);
                    end else if (repeat_en) begin
                        shreg_d   = word_q;
                        bit_idx_d = TOP_IDX;
                    end else begin
                        bit_idx_d = TOP_IDX;
                        done_d    = 1'b1;
                    end
                end
            end
            default: begin
                bit_idx_d = TOP_IDX;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and parks the index at the MSB.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            word_q    <= '0;
            shreg_q   <= '0;
            bit_idx_q <= TOP_IDX;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
        end
    end

    assign w_out   = in_shift & shreg_q[WIDTH-1];
    assign w_valid = in_shift;
    assign busy    = in_shift;
    assign done    = done_q;
    assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Testbench for serial_bit_feeder: per-cycle comparison against a timing model of the
// serial stream, literal checks of bit sequences and pulse timing, and a TICK_DIV=1
// instance feeding a 1101 pattern detector.
module tb_serial_bit_feeder;

    localparam int W  = 8;
    localparam int TD = 3;

    typedef struct {
        logic       w_out;
        logic       w_valid;
        logic       strobe;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data_in = '0;
    logic       repeat_en = 1'b0;
    logic       abort = 1'b0;
    logic       w_out, w_valid, bit_strobe, busy, done;
    logic [2:0] bit_idx;

    logic       load2 = 1'b0;
    logic [7:0] data2 = '0;
    logic       repeat2 = 1'b0;
    logic       abort2 = 1'b0;
    logic       w_out2, w_valid2, strobe2, busy2, done2;
    logic [2:0] idx2;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    int         cyc_cnt = 0;
    int         strobe_cnt = 0;
    int         done_cnt = 0;
    int         done_at = 0;
    int         valid_cnt = 0;
    logic [7:0] cap = '0;

    int         bit_no = 0;
    int         match_cnt = 0;
    int         match_pos = -1;
    int         match_idx = -1;
    int         done2_cnt = 0;
    int         busy2_cnt = 0;
    logic [3:0] hist = '0;
    logic [7:0] cap2 = '0;

    int         lit_req = 0;
    int         lit_done = 0;
    string      lit_name = "";
    int         lit_act = 0;
    int         lit_exp = 0;

    bit         m_active = 1'b0;
    logic [7:0] m_word = '0;
    int         m_t = 0;

    serial_bit_feeder #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .load(load), .data_in(data_in),
        .repeat_en(repeat_en), .abort(abort), .w_out(w_out), .w_valid(w_valid),
        .bit_strobe(bit_strobe), .busy(busy), .done(done), .bit_idx(bit_idx)
    );

    serial_bit_feeder #(.WIDTH(W), .TICK_DIV(1)) dut_fast (
        .clock(clock), .reset(reset), .load(load2), .data_in(data2),
        .repeat_en(repeat2), .abort(abort2), .w_out(w_out2), .w_valid(w_valid2),
        .bit_strobe(strobe2), .busy(busy2), .done(done2), .bit_idx(idx2)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_cnt, act, expv);
        end
    endtask

    // Single compare process: model queue every cycle, plus literal checks posted by the main flow.
    initial begin : compare_proc
        exp_t e;
        forever begin
            @(negedge clock);
            cyc_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("w_out", {31'd0, w_out}, {31'd0, e.w_out});
                cmp("w_valid", {31'd0, w_valid}, {31'd0, e.w_valid});
                cmp("bit_strobe", {31'd0, bit_strobe}, {31'd0, e.strobe});
                cmp("busy", {31'd0, busy}, {31'd0, e.busy});
                cmp("done", {31'd0, done}, {31'd0, e.done});
                if (e.w_valid) begin
                    cmp("bit_idx", {29'd0, bit_idx}, {29'd0, e.idx});
                end
            end
            if (bit_strobe === 1'b1) begin
                strobe_cnt++;
                cap = {cap[6:0], w_out};
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc_cnt;
            end
            if (w_valid === 1'b1) begin
                valid_cnt++;
            end
            if (lit_req != lit_done) begin
                cmp(lit_name, lit_act, lit_exp);
                lit_done = lit_req;
            end
        end
    end

    // Pattern detector fed by the fast instance: advances only on bit_strobe, looks for 1101.
    initial begin : detector_proc
        forever begin
            @(negedge clock);
            if (done2 === 1'b1) done2_cnt++;
            if (busy2 === 1'b1) busy2_cnt++;
            if (strobe2 === 1'b1 && w_valid2 === 1'b1) begin
                hist = {hist[2:0], w_out2};
                cap2 = {cap2[6:0], w_out2};
                if (hist == 4'b1101) begin
                    match_cnt++;
                    match_pos = bit_no;
                    match_idx = int'(idx2);
                end
                bit_no++;
            end
        end
    end

    // Drives one clock of inputs and queues the outputs the stream model predicts after that edge.
    task automatic applyStimulus(input logic ld, input logic [7:0] d, input logic rep,
                                 input logic ab, input logic rst);
        exp_t e;
        int   tw;
        int   idx;
        reset     = rst;
        load      = ld;
        data_in   = d;
        repeat_en = rep;
        abort     = ab;
        e.w_out = 1'b0; e.w_valid = 1'b0; e.strobe = 1'b0;
        e.busy  = 1'b0; e.done    = 1'b0; e.idx    = 3'd7;
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (ld) begin
                m_active = 1'b1;
                m_word   = d;
                m_t      = 0;
            end
        end else begin
            if (ab) begin
                m_active = 1'b0;
            end else if ((m_t % (W * TD)) == W * TD - 1) begin
                if (rep) begin
                    m_t++;
                end else begin
                    m_active = 1'b0;
                    e.done   = 1'b1;
                end
            end else begin
                m_t++;
            end
        end
        if (m_active) begin
            tw        = m_t % (W * TD);
            idx       = W - 1 - tw / TD;
            e.idx     = 3'(idx);
            e.w_out   = m_word[idx];
            e.w_valid = 1'b1;
            e.busy    = 1'b1;
            e.strobe  = ((tw % TD) == TD - 1);
        end
        @(posedge clock);
        exp_q.push_back(e);
        #2;
    endtask

    // Posts a literal expectation to the compare process and waits until it has been taken.
    task automatic checkOutput(input string name, input int act, input int expv);
        lit_name = name;
        lit_act  = act;
        lit_exp  = expv;
        lit_req++;
        @(negedge clock);
        #1;
    endtask

    task automatic runIdle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    int base_cyc, base_strobe, base_done, base_valid, base_bits, base_match, base_d2, base_b2;

    initial begin : main_proc
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        runIdle(2);

        $display("[TB] reset mid-word");
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        runIdle(10);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("reset_bit_idx", int'(bit_idx), 7);
        checkOutput("reset_w_valid", int'(w_valid), 0);
        checkOutput("reset_done", int'(done), 0);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        runIdle(26);

        $display("[TB] single word B1");
        applyStimulus(1'b1, 8'b1011_0001, 1'b0, 1'b0, 1'b0);
        base_cyc = cyc_cnt; base_strobe = strobe_cnt; base_done = done_cnt;
        runIdle(26);
        checkOutput("b1_bits", int'(cap), 8'hB1);
        checkOutput("b1_strobes", strobe_cnt - base_strobe, 8);
        checkOutput("b1_done_cycle", done_at - base_cyc, 25);
        checkOutput("b1_done_count", done_cnt - base_done, 1);

        $display("[TB] repeat A5");
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        base_cyc = cyc_cnt; base_done = done_cnt; base_valid = valid_cnt;
        for (int k = 1; k <= 74; k++) begin
            applyStimulus(1'b0, 8'h00, (k < 60), 1'b0, 1'b0);
        end
        checkOutput("a5_done_cycle", done_at - base_cyc, 73);
        checkOutput("a5_valid_cycles", valid_cnt - base_valid, 72);
        checkOutput("a5_done_count", done_cnt - base_done, 1);

        $display("[TB] load ignored while shifting");
        applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
        base_done = done_cnt;
        for (int k = 1; k <= 26; k++) begin
            applyStimulus((k <= 9), 8'hFF, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("0f_bits", int'(cap), 8'h0F);
        checkOutput("0f_done_count", done_cnt - base_done, 1);

        $display("[TB] abort at bit 4");
        applyStimulus(1'b1, 8'hE7, 1'b0, 1'b0, 1'b0);
        base_done = done_cnt;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, (k == 10 || k == 12), 1'b0);
        end
        checkOutput("abort_done_count", done_cnt - base_done, 0);
        checkOutput("abort_w_valid", int'(w_valid), 0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        base_done = done_cnt;
        runIdle(26);
        checkOutput("3c_bits", int'(cap), 8'h3C);
        checkOutput("3c_done_count", done_cnt - base_done, 1);

        $display("[TB] fast feeder into 1101 detector");
        base_bits = bit_no; base_match = match_cnt; base_d2 = done2_cnt; base_b2 = busy2_cnt;
        load2 = 1'b1;
        data2 = 8'b0111_0110;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        load2 = 1'b0;
        data2 = 8'h00;
        runIdle(10);
        checkOutput("det_match_count", match_cnt - base_match, 1);
        checkOutput("det_match_pos", match_pos - base_bits, 5);
        checkOutput("det_match_idx", match_idx, 2);
        checkOutput("fast_bits", int'(cap2), 8'h76);
        checkOutput("fast_busy_cycles", busy2_cnt - base_b2, 8);
        checkOutput("fast_done_count", done2_cnt - base_d2, 1);

        runIdle(2);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
